// File: rtl/jdquant_pkg.sv
// Shared types and default sizing for the JPEG dequantizer slice.
package jdquant_pkg;

    localparam int DW_DEF  = 16;
    localparam int QW_DEF  = 8;
    localparam int BLK_DEF = 64;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jdquant_page_param_if.sv
// Stream bundle for the dequantizer: table in, coefficients in, results out.
interface jdquant_page_param_if #(
    parameter int DW = 16,
    parameter int QW = 8
);
    logic [QW-1:0] qtabStream_d;
    logic          qtabStream_e;
    logic          qtabStream_v;
    logic          qtabStream_b;
    logic [DW-1:0] inStream_d;
    logic          inStream_e;
    logic          inStream_v;
    logic          inStream_b;
    logic [DW-1:0] outStream_d;
    logic          outStream_e;
    logic          outStream_v;
    logic          outStream_b;

    modport master (
        output qtabStream_d, qtabStream_e, qtabStream_v,
        input  qtabStream_b,
        output inStream_d, inStream_e, inStream_v,
        input  inStream_b,
        input  outStream_d, outStream_e, outStream_v,
        output outStream_b
    );

    modport slave (
        input  qtabStream_d, qtabStream_e, qtabStream_v,
        output qtabStream_b,
        input  inStream_d, inStream_e, inStream_v,
        output inStream_b,
        output outStream_d, outStream_e, outStream_v,
        input  outStream_b
    );
endinterface

// File: rtl/jdquant_fifo.sv
// Power-of-two input queue; full/empty come straight from a registered count.
module jdquant_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   cnt_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (cnt_r == CNT_FULL);
    assign empty     = (cnt_r == {(AW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rptr_r];

    // storage array; contents are irrelevant once the count is cleared
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_r <= {AW{1'b0}};
            rptr_r <= {AW{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

// File: rtl/jdquant_page_param.sv
// Dequantizer: loads a BLK-entry table, then scales each coefficient by table[idx].
// Optional build macro JDQUANT_SAT_EN selects saturating instead of wrapping reduction.
module jdquant_page_param
    import jdquant_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int QW    = QW_DEF,
    parameter int DEPTH = 4,
    parameter int BLK   = BLK_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [QW-1:0] qtabStream_d,
    input  logic          qtabStream_e,
    input  logic          qtabStream_v,
    output logic          qtabStream_b,
    input  logic [DW-1:0] inStream_d,
    input  logic          inStream_e,
    input  logic          inStream_v,
    output logic          inStream_b,
    output logic [DW-1:0] outStream_d,
    output logic          outStream_e,
    output logic          outStream_v,
    input  logic          outStream_b
);
    localparam int IW = idx_bits(BLK);
    localparam int PW = DW + QW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BLK - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [QW-1:0] Q_ONE    = QW'(1);

    state_t        state_r;
    state_t        state_nx_s;
    logic [QW-1:0] table_r [BLK];
    logic [IW-1:0] lidx_r;
    logic [IW-1:0] idx_r;
    logic          out_v_r;
    logic          out_e_r;
    logic [DW-1:0] out_d_r;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic [DW:0]   head_s;
    logic          head_e_s;
    logic [DW-1:0] head_d_s;
    logic          load_tok_s;
    logic          out_free_s;
    logic          eob_pending_s;
    logic signed [PW-1:0] coef_ext_s;
    logic signed [PW-1:0] qf_ext_s;
    logic signed [PW-1:0] prod_s;

    function automatic logic [DW-1:0] reduce(input logic signed [PW-1:0] p);
`ifdef JDQUANT_SAT_EN
        logic signed [PW-1:0] pmax;
        logic signed [PW-1:0] pmin;
        pmax = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        pmin = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (p > pmax) begin
            return pmax[DW-1:0];
        end else if (p < pmin) begin
            return pmin[DW-1:0];
        end else begin
            return p[DW-1:0];
        end
`else
        return p[DW-1:0];
`endif
    endfunction

    jdquant_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data ({inStream_e, inStream_d}),
        .full      (fifo_full_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s)
    );

    assign push_s        = inStream_v & ~fifo_full_s;
    assign head_e_s      = head_s[DW];
    assign head_d_s      = head_s[DW-1:0];
    assign load_tok_s    = (state_r == LOAD) & qtabStream_v;
    assign out_free_s    = ~out_v_r | ~outStream_b;
    // an end marker waiting in the output register belongs to the old table
    assign eob_pending_s = out_v_r & out_e_r;
    assign pop_s         = (state_r == RUN) & ~fifo_empty_s & out_free_s & ~eob_pending_s;

    assign coef_ext_s = PW'($signed(head_d_s));
    assign qf_ext_s   = $signed(PW'(table_r[idx_r]));
    assign prod_s     = coef_ext_s * qf_ext_s;

    assign qtabStream_b = (state_r == RUN);
    assign inStream_b   = fifo_full_s;
    assign outStream_v  = out_v_r;
    assign outStream_e  = out_e_r;
    assign outStream_d  = out_d_r;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LOAD: begin
                if (load_tok_s && (qtabStream_e || (lidx_r == LAST_IDX))) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = LOAD;
                end
            end
            RUN: begin
                if (eob_pending_s && !outStream_b) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: state_nx_s = LOAD;
        endcase
    end

    // quant table and its load index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BLK; i++) begin
                table_r[i] <= Q_ONE;
            end
            lidx_r <= {IW{1'b0}};
        end else if (load_tok_s) begin
            if (qtabStream_e || (lidx_r == LAST_IDX)) begin
                lidx_r <= {IW{1'b0}};
            end else begin
                lidx_r <= lidx_r + IDX_ONE;
            end
            if (!qtabStream_e) begin
                table_r[lidx_r] <= qtabStream_d;
            end
        end
    end

    // coefficient index within the block
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_r <= {IW{1'b0}};
        end else if (pop_s) begin
            if (head_e_s || (idx_r == LAST_IDX)) begin
                idx_r <= {IW{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_ONE;
            end
        end
    end

    // output register; holds while the consumer is busy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_v_r <= 1'b0;
            out_e_r <= 1'b0;
            out_d_r <= {DW{1'b0}};
        end else if (pop_s) begin
            out_v_r <= 1'b1;
            out_e_r <= head_e_s;
            out_d_r <= head_e_s ? {DW{1'b0}} : reduce(prod_s);
        end else if (!outStream_b) begin
            out_v_r <= 1'b0;
            out_e_r <= 1'b0;
        end
    end
endmodule

// File: doc/jdquant_page_param.md
JDQUANT_PAGE_PARAM -- requirements
Module: jdquant_page_param

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the coefficient and output data width in bits (signed).
REQ-002 SHALL have parameter QW, default 8, meaning the quant-table entry width in bits (unsigned).
REQ-003 SHALL have parameter DEPTH, default 4, meaning the input queue depth (power of 2, >=2).
REQ-004 SHALL have parameter BLK, default 64, meaning the coefficients per block, which is also the number of table entries.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports qtabStream_d, input, QW bits: quant table entry.
REQ-008 SHALL have ports qtabStream_e / _v, input, 1 bit each, and qtabStream_b, output, 1 bit: end-of-stream, valid and busy for the table stream.
REQ-009 SHALL have ports inStream_d, input, DW bits: quantized coefficient.
REQ-010 SHALL have ports inStream_e / _v, input, 1 bit each, and inStream_b, output, 1 bit: end-of-stream, valid and busy for the coefficient stream.
REQ-011 SHALL have ports outStream_d, output, DW bits: dequantized coefficient.
REQ-012 SHALL have ports outStream_e / _v, output, 1 bit each, and outStream_b, input, 1 bit: end-of-stream, valid and busy for the output stream.

Function
REQ-013 SHALL transfer a token on any stream exactly in a cycle with _v=1 and _b=0; an _e=1 token is an end-of-stream marker, and its _d is don't-care.
REQ-014 SHALL buffer inStream in a DEPTH-entry FIFO; inStream_b=1 iff FIFO full; a simultaneous push and pop when full SHALL NOT be permitted (b already high).
REQ-015 SHALL use FSM states LOAD and RUN; reset enters LOAD.
REQ-016 In LOAD: qtabStream_b=0; each data token writes table[lidx], lidx increments; FIFO pop disabled (FIFO may still fill).
REQ-017 In LOAD: after BLK data tokens, or on any qtab _e token, SHALL enter RUN next cycle with lidx=0; entries not written keep prior values.
REQ-018 In RUN: qtabStream_b=1; pop FIFO head when output register empty or outStream_b=0 (one token/cycle sustained).
REQ-019 Data token popped SHALL produce outStream_d = f(signed d * unsigned table[idx]), registered, valid the next cycle (latency 1 from pop).
REQ-020 The index idx SHALL increment per data token and wrap BLK-1 -> 0.
REQ-021 An _e token popped SHALL be forwarded as outStream_e=1, outStream_d=0, SHALL reset idx to 0, and the FSM SHALL return to LOAD once that token leaves the output register.
REQ-022 Output register SHALL hold _d/_e/_v stable while outStream_b=1.
REQ-023 Product SHALL be computed at DW+QW+1 bits signed before reduction f.

Reset
REQ-024 On reset low: outStream_v=0, outStream_e=0, outStream_d=0, FIFO empty, inStream_b=0, qtabStream_b=0, idx=lidx=0, state LOAD, table entries all 1.
REQ-025 Reset asserted mid-block SHALL discard FIFO and output contents immediately, without waiting for a clock edge.

Configuration
REQ-026 With JDQUANT_SAT_EN defined, f SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-027 Without JDQUANT_SAT_EN, f SHALL take the low DW bits (two's-complement wrap).

Structure
REQ-028 Package jdquant_pkg SHALL hold the LOAD/RUN state enum and the default DW/QW/BLK constants.
REQ-029 The input FIFO SHALL be sub-module jdquant_fifo (params W=DW+1, DEPTH); the multiply/reduce and FSM SHALL stay in the top level.

Verification
REQ-030 Load 64 entries all 2, send coeffs 1..64 with outStream_b=0 -> outputs 2..128, one per cycle after the first, idx wraps.
REQ-031 Load table[0]=255, send coeff -200 (DW=16) -> -51000 wraps to 14536 without the macro; -32768 with JDQUANT_SAT_EN.
REQ-032 Hold outStream_b=1 for 10 cycles while sending 8 coeffs -> inStream_b=1 after DEPTH+1 accepted, no loss, order preserved.
REQ-033 Send qtab _e after 3 entries (5,6,7) -> RUN; coeffs 1,1,1,1 -> 5,6,7,1.
REQ-034 Send 10 coeffs then an _e token, then new table of all 3 -> _e forwarded with d=0, FSM in LOAD, next block output starts with idx 0 and factor 3.
REQ-035 Assert reset with FIFO half full and output valid -> outStream_v=0 asynchronously, FSM LOAD, table all 1.
